// File: rtl/dsp_alu_arbiter.sv
// Shares one nibble-serial ALU between two requesters: a, b, op, execute, wait for done, respond.
// Build with ARB_FIXED_PRIORITY_EN defined to make requester 0 always win ties (no rr_ptr).
module dsp_alu_arbiter #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int TO_W           = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_op,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags,
  output logic       rsp_err,
  output logic       alu_reset,
  output logic       alu_process,
  output logic [3:0] alu_data,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_flags
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, SEND_OP, EXEC, WAIT, RESP
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      a_q, b_q, op_q;
  logic            id_q;
  logic [TO_W-1:0] to_cnt, cnt_nxt;
  logic            win;
  logic            grant_ok;

  logic            proc_nxt, alu_reset_nxt, err_nxt;
  logic [3:0]      data_nxt, res_nxt;
  logic [2:0]      flg_nxt;
  logic [1:0]      rsp_valid_nxt;

`ifdef ARB_FIXED_PRIORITY_EN
  assign win = ~req_valid[0];
`else
  logic rr_ptr;

  assign win = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= 1'b0;
    else if (grant_ok)
      rr_ptr <= ~win;
  end
`endif

  // The ALU is still being resynced while alu_reset is high, so no grant then.
  assign grant_ok  = (state == IDLE) && !alu_reset && (req_valid != 2'b00);
  assign req_ready = {win, ~win} & {2{grant_ok}};

  always_comb begin
    state_nxt     = state;
    proc_nxt      = 1'b0;
    data_nxt      = 4'h0;
    alu_reset_nxt = 1'b0;
    rsp_valid_nxt = rsp_valid;
    res_nxt       = rsp_result;
    flg_nxt       = rsp_flags;
    err_nxt       = rsp_err;
    cnt_nxt       = to_cnt;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          state_nxt = SEND_A;
          proc_nxt  = 1'b1;
          data_nxt  = req_a[{win, 2'b00} +: 4];
        end
      end
      SEND_A: begin
        state_nxt = SEND_B;
        proc_nxt  = 1'b1;
        data_nxt  = b_q;
      end
      SEND_B: begin
        state_nxt = SEND_OP;
        proc_nxt  = 1'b1;
        data_nxt  = op_q;
      end
      SEND_OP: begin
        state_nxt = EXEC;
        proc_nxt  = 1'b1;
      end
      EXEC: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        if (alu_flags[0]) begin
          state_nxt     = RESP;
          rsp_valid_nxt = {id_q, ~id_q};
          res_nxt       = alu_result;
          flg_nxt       = alu_flags[3:1];
          err_nxt       = 1'b0;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this operation and knock the ALU back to its start state.
          state_nxt     = RESP;
          rsp_valid_nxt = {id_q, ~id_q};
          res_nxt       = 4'h0;
          flg_nxt       = 3'b000;
          err_nxt       = 1'b1;
          alu_reset_nxt = 1'b1;
        end else begin
          cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[id_q]) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 2'b00;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rsp_valid   <= 2'b00;
      rsp_result  <= 4'h0;
      rsp_flags   <= 3'b000;
      rsp_err     <= 1'b0;
      alu_reset   <= 1'b1;
      alu_process <= 1'b0;
      alu_data    <= 4'h0;
      to_cnt      <= '0;
      a_q         <= 4'h0;
      b_q         <= 4'h0;
      op_q        <= 4'h0;
      id_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_result  <= res_nxt;
      rsp_flags   <= flg_nxt;
      rsp_err     <= err_nxt;
      alu_reset   <= alu_reset_nxt;
      alu_process <= proc_nxt;
      alu_data    <= data_nxt;
      to_cnt      <= cnt_nxt;
      if (grant_ok) begin
        a_q  <= req_a[{win, 2'b00} +: 4];
        b_q  <= req_b[{win, 2'b00} +: 4];
        op_q <= req_op[{win, 2'b00} +: 4];
        id_q <= win;
      end
    end
  end

endmodule

// File: tb/tb_dsp_alu_arbiter.sv
// Directed bench for dsp_alu_arbiter with a small nibble-serial ALU model attached.
module tb_dsp_alu_arbiter;

  localparam int TIMEOUT_CYCLES = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a, req_b, req_op;
  logic [3:0] rsp_result, alu_data, alu_result, alu_flags;
  logic [2:0] rsp_flags;
  logic       rsp_err, alu_reset, alu_process;

  int errors = 0;
  int checks = 0;

  dsp_alu_arbiter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_reset(alu_reset), .alu_process(alu_process), .alu_data(alu_data),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, others ~a. Returns {carry, result}.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, b, op);
    case (op)
      4'd0:    alu_fn = {1'b0, a} + {1'b0, b};
      4'd1:    alu_fn = {(a < b), a - b};
      4'd2:    alu_fn = {1'b0, a & b};
      4'd3:    alu_fn = {1'b0, a | b};
      4'd4:    alu_fn = {1'b0, a ^ b};
      default: alu_fn = {1'b0, ~a};
    endcase
  endfunction

  logic [1:0] m_ph;
  logic [3:0] m_a, m_b;
  logic       m_done, m_c, alu_stuck;
  logic [4:0] m_cr;

  assign m_cr       = alu_fn(m_a, m_b, alu_data);
  assign alu_flags  = {alu_result[3], (alu_result == 4'h0), m_c, m_done};

  always_ff @(posedge clk) begin
    if (alu_reset) begin
      m_ph <= 2'd0; m_done <= 1'b0; alu_result <= 4'h0; m_c <= 1'b0;
      m_a <= 4'h0; m_b <= 4'h0;
    end else if (alu_process) begin
      m_ph <= m_ph + 2'd1;
      case (m_ph)
        2'd0: begin m_a <= alu_data; m_done <= 1'b0; end
        2'd1: m_b <= alu_data;
        2'd2: begin alu_result <= m_cr[3:0]; m_c <= m_cr[4]; end
        default: m_done <= !alu_stuck;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction starting in IDLE with requester id expected to win.
  task automatic serve(input int id, input logic [3:0] a, b, op, res, input logic [2:0] flg);
    logic [7:0] sa, sb, so;
    chk("grant", req_ready, 32'(1 << id));
    tick;
    sa = req_a; sb = req_b; so = req_op;
    req_a = ~sa; req_b = ~sb; req_op = ~so;
    chk("drive_a", {alu_process, alu_data}, {1'b1, a});
    chk("busy_ready", req_ready, 0);
    tick; chk("drive_b", {alu_process, alu_data}, {1'b1, b});
    tick; chk("drive_op", {alu_process, alu_data}, {1'b1, op});
    tick; chk("drive_exec", {alu_process, alu_data}, {1'b1, 4'h0});
    tick; chk("wait_idle", {alu_process, rsp_valid}, 0);
    req_a = sa; req_b = sb; req_op = so;
    tick;
    chk("rsp_valid", rsp_valid, 32'(1 << id));
    chk("rsp_data", {rsp_err, rsp_flags, rsp_result}, {1'b0, flg, res});
    rsp_ready = 2'(1 << id);
    tick;
    rsp_ready = 2'b00;
    chk("rsp_clear", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; alu_stuck = 1'b0;
    req_a = 8'h00; req_b = 8'h00; req_op = 8'h00;
    tick; tick;
    chk("rst_outs", {rsp_valid, rsp_result, rsp_flags, rsp_err, alu_process, alu_data},
        0);
    chk("rst_alu_reset", alu_reset, 1);
    reset = 1'b0; req_valid = 2'b01; #1;
    chk("rst_extra_cycle", {alu_reset, req_ready}, {1'b1, 2'b00});
    req_valid = 2'b00;
    tick;
    chk("rst_alu_reset_low", alu_reset, 0);

    // Lone requester 0, back-to-back.
    req_valid = 2'b01; req_a = 8'h03; req_b = 8'h04; req_op = 8'h00; #1;
    serve(0, 4'h3, 4'h4, 4'h0, 4'h7, 3'b000);
    req_a = 8'h09; req_b = 8'h08; req_op = 8'h00; #1;
    serve(0, 4'h9, 4'h8, 4'h0, 4'h1, 3'b001);

    // Undefined opcode on requester 1 is forwarded as-is.
    req_valid = 2'b10; req_a = 8'h10; req_b = 8'h20; req_op = 8'h90; #1;
    serve(1, 4'h1, 4'h2, 4'h9, 4'hE, 3'b100);

    // Simultaneous requests from reset.
    reset = 1'b1; req_valid = 2'b00; tick; reset = 1'b0; tick;
    req_valid = 2'b11; req_a = 8'hC5; req_b = 8'h35; req_op = 8'h31; #1;
    serve(0, 4'h5, 4'h5, 4'h1, 4'h0, 3'b010);
`ifdef ARB_FIXED_PRIORITY_EN
    serve(0, 4'h5, 4'h5, 4'h1, 4'h0, 3'b010);
    serve(0, 4'h5, 4'h5, 4'h1, 4'h0, 3'b010);
`else
    serve(1, 4'hC, 4'h3, 4'h3, 4'hF, 3'b100);
    serve(0, 4'h5, 4'h5, 4'h1, 4'h0, 3'b010);
    serve(1, 4'hC, 4'h3, 4'h3, 4'hF, 3'b100);
`endif

    // Timeout: done never arrives.
    alu_stuck = 1'b1;
    req_valid = 2'b01; req_a = 8'h02; req_b = 8'h02; req_op = 8'h00; #1;
    chk("to_grant", req_ready, 2'b01);
    for (int i = 0; i < 5; i++) tick;
    for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
      tick;
      chk("to_waiting", rsp_valid, 0);
    end
    tick;
    chk("to_rsp", {rsp_valid, rsp_err, rsp_flags, rsp_result}, {2'b01, 1'b1, 7'h00});
    chk("to_alu_reset", alu_reset, 1);
    req_valid = 2'b11;
    tick;
    chk("to_alu_reset_pulse", alu_reset, 0);
    alu_stuck = 1'b0;

    // Response held with no consumer; ready on the other bit is ignored.
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("hold", {rsp_valid, rsp_err, rsp_flags, rsp_result, req_ready, alu_process},
          {2'b01, 1'b1, 7'h00, 2'b00, 1'b0});
    end
    rsp_ready = 2'b01; tick; rsp_ready = 2'b00;
    chk("to_rsp_clear", rsp_valid, 0);
    req_valid = 2'b01; req_a = 8'h06; req_b = 8'h02; req_op = 8'h02; #1;
    serve(0, 4'h6, 4'h2, 4'h2, 4'h2, 3'b000);

    // Reset during SEND_B.
    req_a = 8'h01; req_b = 8'h02; req_op = 8'h00; #1;
    tick; tick;
    chk("mid_send_b", {alu_process, alu_data}, {1'b1, 4'h2});
    reset = 1'b1;
    tick;
    chk("mid_rst_outs",
        {rsp_valid, rsp_result, rsp_flags, rsp_err, alu_process, alu_data, req_ready}, 0);
    chk("mid_rst_alu_reset", alu_reset, 1);
    reset = 1'b0; #1;
    chk("mid_rst_extra", {alu_reset, req_ready}, {1'b1, 2'b00});
    tick;
    chk("mid_rst_done", {alu_reset, alu_process, req_ready}, {1'b0, 1'b0, 2'b01});
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_reissue", {alu_process, rsp_valid}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
